// File: rtl/popcount_mmio_accel_pkg.sv
// Shared definitions for the memory-mapped popcount accelerator:
// register offsets, STATUS bit positions, FSM encoding and count widths.
package popcount_mmio_accel_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0200;

  // acc/RESULT and cyc/CYCLES hold values up to 32, so 6 bits is enough
  localparam int CNT_W = 6;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_OPERAND = 2'd1,
    REG_RESULT  = 2'd2,
    REG_CYCLES  = 2'd3
  } reg_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [31:0] zext_cnt(input logic [CNT_W-1:0] v);
    return {{(32-CNT_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/popcount_mmio_accel_popcount_slice.sv
// Combinational popcount of a W-bit slice; W is at most 8, so the count
// always fits the shared accumulator width.
module popcount_slice
  import popcount_mmio_accel_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]     bits_i,
  output logic [CNT_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/popcount_mmio_accel.sv
// Bit-count accelerator on the core data bus: register window decode,
// IDLE/RUN engine that consumes BITS_PER_CYCLE operand bits per cycle.
//
// state | meaning
// IDLE  | waiting for START; OPERAND writable, RESULT/CYCLES hold last op
// RUN   | shifting operand, accumulating count; exits when the rest is zero
module popcount_mmio_accel
  import popcount_mmio_accel_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
  parameter int          BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        Busy
);

  state_e             state_q,   state_d;
  logic [31:0]        operand_q, operand_d;
  logic [31:0]        sh_q,      sh_d;
  logic [CNT_W-1:0]   acc_q,     acc_d;
  logic [CNT_W-1:0]   cyc_q,     cyc_d;
  logic [CNT_W-1:0]   result_q,  result_d;
  logic [CNT_W-1:0]   cycles_q,  cycles_d;
  logic               done_q,    done_d;

  reg_sel_e           reg_sel;
  logic               wr_en;
  logic               start_req;
  logic               operand_wr;
  logic [CNT_W-1:0]   slice_cnt;
  logic [31:0]        sh_shift;
  logic [CNT_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   cyc_inc;
  logic [1:0]         unused_byte_offset;

  // Byte lane bits are ignored; the window is word-addressed.
  assign unused_byte_offset = ALUResult[1:0];

  assign Hit        = (ALUResult[31:4] == BASE_ADDR[31:4]);
  assign reg_sel    = reg_sel_e'(ALUResult[3:2]);
  assign wr_en      = MemWrite && Hit;
  assign start_req  = wr_en && (reg_sel == REG_CTRL) && WriteData[0];
  assign operand_wr = wr_en && (reg_sel == REG_OPERAND);
  assign Busy       = (state_q == ST_RUN);

  popcount_slice #(
    .W (BITS_PER_CYCLE)
  ) u_slice (
    .bits_i  (sh_q[BITS_PER_CYCLE-1:0]),
    .count_o (slice_cnt)
  );

  assign sh_shift = sh_q >> BITS_PER_CYCLE;
  assign acc_sum  = acc_q + slice_cnt;
  assign cyc_inc  = cyc_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    cyc_d     = cyc_q;
    result_d  = result_q;
    cycles_d  = cycles_q;
    done_d    = done_q;

    unique case (state_q)
      ST_IDLE: begin
        if (operand_wr) begin
          operand_d = WriteData;
        end
        if (start_req) begin
          state_d = ST_RUN;
          sh_d    = operand_q;
          acc_d   = '0;
          cyc_d   = '0;
          done_d  = 1'b0;
        end
      end
      ST_RUN: begin
        sh_d  = sh_shift;
        acc_d = acc_sum;
        cyc_d = cyc_inc;
        // Exit as soon as no set bits remain above the current slice.
        if (sh_shift == '0) begin
          state_d  = ST_IDLE;
          result_d = acc_sum;
          cycles_d = cyc_inc;
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      operand_q <= '0;
      sh_q      <= '0;
      acc_q     <= '0;
      cyc_q     <= '0;
      result_q  <= '0;
      cycles_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      cyc_q     <= cyc_d;
      result_q  <= result_d;
      cycles_q  <= cycles_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    ReadData = '0;
    if (Hit) begin
      unique case (reg_sel)
        REG_CTRL: begin
          ReadData[STATUS_BUSY_BIT] = Busy;
          ReadData[STATUS_DONE_BIT] = done_q;
        end
        REG_OPERAND: ReadData = operand_q;
        REG_RESULT:  ReadData = zext_cnt(result_q);
        REG_CYCLES:  ReadData = zext_cnt(cycles_q);
        default:     ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_mmio_accel.sv
// Scoreboard bench: three accelerators (1, 4 and 8 bits per cycle) share one
// bus; a transaction-level model predicts every read, a monitor checks them.
module tb_popcount_mmio_accel;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic        rd_en = 1'b0;
  logic [31:0] rdata [3];
  logic        hit   [3];
  logic        busy  [3];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  popcount_mmio_accel #(.BASE_ADDR(32'h0000_0200), .BITS_PER_CYCLE(1)) u_dut_b1 (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(rdata[0]), .Hit(hit[0]), .Busy(busy[0]));
  popcount_mmio_accel #(.BASE_ADDR(32'h0000_0200), .BITS_PER_CYCLE(4)) u_dut_b4 (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(rdata[1]), .Hit(hit[1]), .Busy(busy[1]));
  popcount_mmio_accel #(.BASE_ADDR(32'h0000_0200), .BITS_PER_CYCLE(8)) u_dut_b8 (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(rdata[2]), .Hit(hit[2]), .Busy(busy[2]));

  // ---------------- reference model (per instance, transaction level) -----
  logic [31:0] m_operand [3];
  int          m_result  [3];
  int          m_cycles  [3];
  bit          m_done    [3];
  bit          m_pending [3];
  int          m_end     [3];
  int          m_new_res [3];
  int          m_new_cyc [3];

  function automatic int bpc_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 8;
  endfunction

  function automatic int latency(logic [31:0] op, int b);
    int msb;
    msb = -1;
    for (int k = 0; k < 32; k++) if (op[k]) msb = k;
    if (msb < 0) return 1;
    return (msb + b) / b;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_operand[i] = '0; m_result[i] = 0; m_cycles[i] = 0;
      m_done[i] = 0; m_pending[i] = 0; m_end[i] = 0;
    end
  endfunction

  function automatic void settle(int n);
    for (int i = 0; i < 3; i++)
      if (m_pending[i] && n >= m_end[i]) begin
        m_result[i]  = m_new_res[i];
        m_cycles[i]  = m_new_cyc[i];
        m_done[i]    = 1;
        m_pending[i] = 0;
      end
  endfunction

  function automatic bit m_busy(int i, int n);
    return m_pending[i] && (n < m_end[i]);
  endfunction

  function automatic logic [31:0] m_read(int i, logic [31:0] addr, int n);
    if (addr[31:4] != 28'h000_0020) return 32'h0;
    case (addr[3:2])
      2'd0:    return {30'h0, m_done[i], m_busy(i, n)};
      2'd1:    return m_operand[i];
      2'd2:    return 32'(m_result[i]);
      default: return 32'(m_cycles[i]);
    endcase
  endfunction

  // ---------------- scoreboard ---------------------------------------------
  typedef struct {
    string            name;
    logic [2:0][31:0] rd;
    logic             hit;
    logic [2:0]       bsy;
  } exp_t;
  exp_t sb[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rd_en) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sb_empty: got read with no expectation expected queued entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("%s.bpc%0d.rd", e.name, bpc_of(i)), rdata[i], e.rd[i]);
          chk($sformatf("%s.bpc%0d.hit", e.name, bpc_of(i)), 32'(hit[i]), 32'(e.hit));
          chk($sformatf("%s.bpc%0d.busy", e.name, bpc_of(i)), 32'(busy[i]), 32'(e.bsy[i]));
        end
      end
    end
  end

  // ---------------- bus tasks ----------------------------------------------
  task automatic do_idle();
    @(posedge clk); #1;
    MemWrite = 0; rd_en = 0;
  endtask

  task automatic do_write(logic [31:0] addr, logic [31:0] data);
    int n;
    @(posedge clk); #1;
    rd_en = 0; MemWrite = 1; ALUResult = addr; WriteData = data;
    n = cyc_n;
    settle(n);
    if (addr[31:4] == 28'h000_0020) begin
      for (int i = 0; i < 3; i++) begin
        if (!m_busy(i, n)) begin
          if (addr[3:2] == 2'd1) m_operand[i] = data;
          if (addr[3:2] == 2'd0 && data[0]) begin
            m_pending[i] = 1;
            m_new_cyc[i] = latency(m_operand[i], bpc_of(i));
            m_new_res[i] = $countones(m_operand[i]);
            m_end[i]     = n + 1 + m_new_cyc[i];
            m_done[i]    = 0;
          end
        end
      end
    end
  endtask

  task automatic do_read(logic [31:0] addr, string name);
    exp_t e;
    @(posedge clk); #1;
    MemWrite = 0; rd_en = 1; ALUResult = addr; WriteData = $urandom;
    settle(cyc_n);
    e.name = name;
    e.hit  = (addr[31:4] == 28'h000_0020);
    for (int i = 0; i < 3; i++) begin
      e.rd[i]  = m_read(i, addr, cyc_n);
      e.bsy[i] = m_busy(i, cyc_n);
    end
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    MemWrite = 0; rd_en = 0; reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_reset();
  endtask

  task automatic read_all(string tag);
    do_read(32'h200, {tag, ".status"});
    do_read(32'h204, {tag, ".operand"});
    do_read(32'h208, {tag, ".result"});
    do_read(32'h20C, {tag, ".cycles"});
  endtask

  task automatic run_op(logic [31:0] op, int polls, string tag);
    do_write(32'h204, op);
    do_write(32'h200, 32'h1);
    for (int k = 0; k < polls; k++) do_read(32'h200, {tag, ".poll"});
    read_all(tag);
  endtask

  // ---------------- stimulus -----------------------------------------------
  initial begin
    model_reset();
    do_reset();
    read_all("reset");

    // abandon a run two cycles in
    do_write(32'h204, 32'hFFFF_FFFF);
    do_write(32'h200, 32'h1);
    do_idle();
    do_reset();
    do_read(32'h200, "midrun_rst.status");
    do_idle(); do_idle();
    read_all("midrun_rst.later");

    run_op(32'hFFFF_FFFF, 34, "all_ones");
    run_op(32'h0000_0000, 3,  "zero");
    run_op(32'h8000_0000, 34, "msb_only");
    run_op(32'h0000_0001, 3,  "lsb_only");

    // writes while busy are dropped
    do_write(32'h204, 32'hC7B5_2169);
    do_write(32'h200, 32'h1);
    do_write(32'h204, 32'h0);
    do_write(32'h200, 32'h1);
    for (int k = 0; k < 34; k++) do_read(32'h200, "busy_ign.poll");
    read_all("busy_ign");

    // outside window, read-only regs, CTRL without START, byte offsets
    do_read(32'h150, "miss_150");
    do_read(32'h210, "miss_210");
    do_read(32'h1FC, "miss_1fc");
    do_write(32'h208, 32'hDEAD_BEEF);
    do_write(32'h20C, 32'h1234_5678);
    do_write(32'h200, 32'hFFFF_FFFE);
    do_write(32'h150, 32'h1);
    read_all("ro_regs");
    do_read(32'h207, "byte_off");

    // randomized operations, short polls, stray writes, occasional reset
    for (int t = 0; t < 24; t++) begin
      logic [31:0] op;
      int sh;
      op = $urandom;
      sh = $urandom_range(0, 32);
      op = (sh == 32) ? 32'h0 : (op >> sh);
      do_write(32'h204, op);
      do_write(32'h200, {$urandom_range(0, 3) != 0 ? 31'h0 : 31'($urandom), 1'b1});
      for (int k = $urandom_range(0, 6); k > 0; k--) do_read(32'h200, "rnd.poll");
      if ($urandom_range(0, 3) == 0)
        do_write({28'h000_0020, 2'($urandom), 2'b00}, $urandom);
      if ($urandom_range(0, 7) == 0) do_reset();
      for (int k = $urandom_range(0, 36); k > 0; k--) do_read(32'h200, "rnd.poll2");
      read_all("rnd");
    end

    do_idle();
    do_idle();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
